// File: rtl/gf233_pkg.sv
// Shared GF(2^233) datapath constants, FSM encoding and small carry-less helpers.
// Imported by the digit-serial multiplier and the downstream reducer.
package gf233_pkg;

  localparam int N          = 233;
  localparam int DIGIT_W    = 30;
  localparam int NUM_DIGITS = 8;
  localparam int PROD_W     = 465;
  localparam int ACC_W      = 479;
  localparam int OPW        = NUM_DIGITS * DIGIT_W;
  localparam int KA_W       = 2 * DIGIT_W - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Schoolbook carry-less product of two 15-bit halves, the leaf of the Karatsuba split.
  function automatic logic [28:0] clmul15(input logic [14:0] a, input logic [14:0] b);
    logic [28:0] r;
    r = 29'b0;
    for (int k = 0; k < 15; k++) begin
      if (b[k]) begin
        r = r ^ (29'(a) << k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gf233_digit_serial_mul_chk.sv
// Property checker: accumulator bits above the 465-bit product must stay zero once done.
module gf233_digit_serial_mul_chk
  import gf233_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  input logic [1:0]                i_state,
  input logic [ACC_W-PROD_W-1:0]   i_acc_hi
);

  a_acc_hi_zero: assert property (@(posedge clk) disable iff (rst)
    (i_state == ST_DONE) |-> (i_acc_hi == {(ACC_W-PROD_W){1'b0}}));

endmodule

// File: rtl/gf233_digit_serial_mul_ka30.sv
// Combinational 30x30 carry-less multiplier, one-level Karatsuba over 15-bit halves.
module gf233_digit_serial_mul_ka30
  import gf233_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  output logic [KA_W-1:0]    o_p
);

  logic [28:0] w_lo;
  logic [28:0] w_hi;
  logic [28:0] w_mid;

  assign w_lo  = clmul15(i_a[14:0], i_b[14:0]);
  assign w_hi  = clmul15(i_a[29:15], i_b[29:15]);
  // Middle term needs both outer products removed before being placed at x^15.
  assign w_mid = clmul15(i_a[14:0] ^ i_a[29:15], i_b[14:0] ^ i_b[29:15]) ^ w_lo ^ w_hi;

  assign o_p = {30'b0, w_lo} ^ ({30'b0, w_mid} << 15) ^ ({w_hi, 30'b0});

endmodule

// File: rtl/gf233_digit_serial_mul.sv
// Digit-serial 233x233 carry-less multiplier: 64 digit-pair products through one
// KA_30bit core, shift-XOR accumulated, full 465-bit product out on valid/ready.
module gf233_digit_serial_mul
  import gf233_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [N-1:0]      i_a,
  input  logic [N-1:0]      i_b,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [PROD_W-1:0] o_y
);

  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_i;
  logic [2:0]       r_j;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [ACC_W-1:0] r_acc;

  logic [7:0]         w_a_off;
  logic [7:0]         w_b_off;
  logic [8:0]         w_shamt;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [KA_W-1:0]    w_prod;
  logic [ACC_W-1:0]   w_prod_sh;

  assign w_a_off = 8'(r_i) * 8'd30;
  assign w_b_off = 8'(r_j) * 8'd30;
  assign w_a_dig = r_a[w_a_off +: DIGIT_W];
  assign w_b_dig = r_b[w_b_off +: DIGIT_W];
  // Digit weights add: A digit i times B digit j lands at x^(30*(i+j)).
  assign w_shamt   = (9'(r_i) + 9'(r_j)) * 9'd30;
  assign w_prod_sh = {{(ACC_W-KA_W){1'b0}}, w_prod} << w_shamt;

  gf233_digit_serial_mul_ka30 u_ka30 (
    .i_a (w_a_dig),
    .i_b (w_b_dig),
    .o_p (w_prod)
  );

  // Control FSM, digit counters, operand capture and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= 3'd0;
      r_j     <= 3'd0;
      r_a     <= {OPW{1'b0}};
      r_b     <= {OPW{1'b0}};
      r_acc   <= {ACC_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_a     <= {{(OPW-N){1'b0}}, i_a};
            r_b     <= {{(OPW-N){1'b0}}, i_b};
            r_acc   <= {ACC_W{1'b0}};
            r_i     <= 3'd0;
            r_j     <= 3'd0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc <= r_acc ^ w_prod_sh;
          r_j   <= r_j + 3'd1;
          if (r_j == LAST_DIG) begin
            r_i <= r_i + 3'd1;
            if (r_i == LAST_DIG) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_y         = r_acc[PROD_W-1:0];

  gf233_digit_serial_mul_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_state  (r_state),
    .i_acc_hi (r_acc[ACC_W-1:PROD_W])
  );

endmodule

// File: tb/tb_gf233_digit_serial_mul.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random operands against a bit-level carry-less multiply model.
module tb_gf233_digit_serial_mul;
  import gf233_pkg::*;

  typedef struct {
    logic [232:0] a;
    logic [232:0] b;
    logic [464:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [232:0] i_a;
  logic [232:0] i_b;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [464:0] o_y;

  int n_checks = 0;
  int n_pass   = 0;

  gf233_digit_serial_mul dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_y         (o_y)
  );

  always #5 clk = ~clk;

  // Carry-less product by definition: XOR of b shifted by every set bit of a.
  function automatic logic [464:0] clmul_ref(input logic [232:0] a, input logic [232:0] b);
    logic [464:0] acc;
    acc = '0;
    for (int k = 0; k < 233; k++) begin
      if (a[k]) acc = acc ^ ({232'b0, b} << k);
    end
    return acc;
  endfunction

  task automatic check(input string name, input logic [464:0] got, input logic [464:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic rand_op(output logic [232:0] r);
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[32*w +: 32] = $urandom;
    r = t[232:0];
  endtask

  // Present operands from a negedge; returns just after the accepting posedge.
  task automatic accept(input logic [232:0] a, input logic [232:0] b);
    i_a = a;
    i_b = b;
    i_in_valid = 1'b1;
    for (int t = 0; t < 300 && !o_in_ready; t++) @(negedge clk);
    if (!o_in_ready) check("accept_timeout", 465'(o_in_ready), 465'd1);
    @(posedge clk);
  endtask

  // lat = index of the first posedge after acceptance at which out_valid is seen.
  task automatic wait_valid(input bit keep_valid, output int lat, output bit ready_seen);
    lat = -1;
    ready_seen = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      i_in_valid = keep_valid;
      if (o_in_ready) ready_seen = 1'b1;
      if (o_out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("valid_timeout", 465'(o_out_valid), 465'd1);
  endtask

  // Holds out_ready low for 'stall' cycles, then completes the handshake.
  task automatic drain(input int stall, output logic [464:0] y);
    y = o_y;
    i_out_ready = 1'b0;
    for (int s = 0; s < stall; s++) @(negedge clk);
    if (stall > 0) check("stall_hold_y", o_y, y);
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [232:0] a, input logic [232:0] b, input int stall,
                       output logic [464:0] y, output int lat, output bit ready_seen);
    accept(a, b);
    wait_valid(1'b0, lat, ready_seen);
    drain(stall, y);
  endtask

  vec_t         vecs[5];
  logic [464:0] y_got;
  logic [464:0] y_hold;
  logic [232:0] ra;
  logic [232:0] rb;
  int           lat;
  bit           rdy;
  bit           vseen;

  initial begin
    vecs[0].a = 233'd1; vecs[0].b = 233'd1; vecs[0].y = 465'd1;
    vecs[1].a = 233'd3; vecs[1].b = 233'd3; vecs[1].y = 465'd5;
    vecs[2].a = 233'd0; vecs[2].a[232] = 1'b1;
    vecs[2].b = 233'd0; vecs[2].b[232] = 1'b1;
    vecs[2].y = 465'd0; vecs[2].y[464] = 1'b1;
    vecs[3].a = {233{1'b1}}; vecs[3].b = 233'd1; vecs[3].y = {232'd0, {233{1'b1}}};
    vecs[4].a = 233'd1; vecs[4].b = {233{1'b1}}; vecs[4].y = {232'd0, {233{1'b1}}};

    rst = 1'b1;
    i_in_valid = 1'b0;
    i_out_ready = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 465'(o_in_ready), 465'd1);
    check("rst_out_valid", 465'(o_out_valid), 465'd0);
    check("rst_y", o_y, 465'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 465'(o_in_ready), 465'd1);

    for (int v = 0; v < 5; v++) begin
      do_op(vecs[v].a, vecs[v].b, 0, y_got, lat, rdy);
      check($sformatf("vec%0d_y", v), y_got, vecs[v].y);
      check($sformatf("vec%0d_latency", v), 465'(lat), 465'd65);
      check($sformatf("vec%0d_in_ready_busy", v), 465'(rdy), 465'd0);
    end

    // Backpressure in DONE while new operands are offered.
    accept(233'h1234_5678_9abc, 233'hfedc_ba98_7654_3210);
    wait_valid(1'b0, lat, rdy);
    y_hold = o_y;
    check("hold_first_y", y_hold, clmul_ref(233'h1234_5678_9abc, 233'hfedc_ba98_7654_3210));
    i_a = {233{1'b1}};
    i_b = 233'h5;
    i_in_valid = 1'b1;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      check("hold_y", o_y, y_hold);
      check("hold_out_valid", 465'(o_out_valid), 465'd1);
      check("hold_in_ready", 465'(o_in_ready), 465'd0);
    end
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_out_ready = 1'b0;
    check("bubble_in_ready", 465'(o_in_ready), 465'd1);
    check("bubble_out_valid", 465'(o_out_valid), 465'd0);
    @(posedge clk);
    wait_valid(1'b0, lat, rdy);
    drain(0, y_got);
    check("after_hold_y", y_got, clmul_ref({233{1'b1}}, 233'h5));
    check("after_hold_latency", 465'(lat), 465'd65);

    // Reset in the middle of the MUL phase.
    accept(233'h7777, 233'h9999);
    vseen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      if (o_out_valid) vseen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 465'(o_out_valid), 465'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 465'(o_in_ready), 465'd1);
    check("midrst_y", o_y, 465'd0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (o_out_valid) vseen = 1'b1;
    end
    check("midrst_no_valid", 465'(vseen), 465'd0);
    do_op(233'h5, 233'h7, 0, y_got, lat, rdy);
    check("post_rst_y", y_got, 465'h1b);

    // Random operands with random backpressure.
    for (int r = 0; r < 1000; r++) begin
      rand_op(ra);
      rand_op(rb);
      do_op(ra, rb, ($urandom_range(0, 3) == 0) ? 2 : 0, y_got, lat, rdy);
      check($sformatf("rand%0d_y", r), y_got, clmul_ref(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf233_digit_serial_mul.md
Name: gf233_digit_serial_mul

Overview:
- Sequential GF(2)[x] multiplier for 233-bit binary-field operands (GF(2^233) datapath, pre-reduction).
- Splits each operand into eight 30-bit digits and feeds one digit pair per cycle into a single combinational KA_30bit core.
- Shift-XOR accumulates the 59-bit partial products into a wide accumulator and emits the full 465-bit carry-less product.
- The downstream reduction stage consumes the output through a valid/ready handshake.

Parameters:
- N, 233: operand width in bits.
- DIGIT_W, 30: digit width. Fixed by the KA_30bit core; any other value is illegal.
- NUM_DIGITS, 8: ceil(N/DIGIT_W). Localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  233  operand A, polynomial coefficients, bit k = x^k.
- b  in  233  operand B, same encoding.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- y  out  465  carry-less product a*b over GF(2), bit k = x^k.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; digit counters i=j=0; accumulator=0; operand registers=0.
  - Outputs: in_ready=1, out_valid=0, y=0. Outputs are registered or decoded from state.
- Reset mid-operation: the partial result is discarded. After rst deasserts the block is in IDLE with in_ready=1. No out_valid is produced for the aborted operation.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch a and b, each zero-extended to 240 bits. Clear the accumulator. Set i=0, j=0. Go to MUL.
  - MUL:
    - in_ready=0.
    - Each cycle: KA_30bit input a = A[30i+29:30i], b = B[30j+29:30j].
    - Accumulator update: acc ^= prod << 30*(i+j).
    - j increments every cycle. On j=7, j wraps to 0 and i increments.
    - After pair (i=7, j=7) is accumulated, go to DONE.
    - Exactly 64 MUL cycles.
  - DONE:
    - out_valid=1; y = acc[464:0], held stable while out_ready=0.
    - On out_ready=1: go to IDLE and clear out_valid.
    - in_ready=0 in DONE, so there is a mandatory one-cycle bubble before the next accept.
- Latency: acceptance edge at T0 gives out_valid=1 from T0+65. Throughput is one product per 66 cycles with out_ready tied high.
- Accumulator:
  - 479 bits wide (max shift 420 plus 59).
  - Bits 478:465 are mathematically zero for 233-bit inputs. An assertion checks them in DONE.
  - Digit 7 bits 239:233 are zero by construction.
- in_valid outside IDLE is ignored; no operand is captured.
- in_valid and out_ready have no combinational path to any output.
- Arithmetic is XOR only; there are no carries.

Decomposition:
- Shared package gf233_pkg holds:
  - N=233, DIGIT_W=30, NUM_DIGITS=8, PROD_W=465, ACC_W=479.
  - The state enum {IDLE, MUL, DONE}.
  - The downstream reducer imports the same package.
- Sub-module: the existing combinational KA_30bit core, instantiated once, unmodified.
- Digit muxes, counters and the accumulator stay in this module.

Test Plan:
- a=1, b=1 -> y=1; out_valid rises exactly 65 cycles after the accept edge; in_ready=0 throughout.
- a=0x3 (x+1), b=0x3 -> y=0x5 (x^2+1); a=x^232, b=x^232 -> only y[464]=1.
- a=all-ones (233 bits), b=1 -> y[232:0]=all-ones and y[464:233]=0. Swapping a and b gives the same result.
- Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> y stable, out_valid held, new operands not captured. After out_ready=1, one bubble cycle, then the next op is accepted and correct.
- Assert rst at cycle 30 of MUL -> out_valid stays 0, in_ready=1 after release. The next op a=0x5, b=0x7 gives y=0x1B.
- 1000 random operand pairs with random out_ready backpressure -> every y matches a bit-level carry-less multiply model; acc[478:465]=0 assertion never fires.
